// File: rtl/medidor_distancia_uc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : medidor_distancia_uc_pkg
// Description : Shared definitions for the ultrasonic distance measurement
//               control unit: 4-bit FSM state codes (also exported on the
//               db_estado debug port), default timing constants derived from
//               a 50 MHz clock, and a small helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package medidor_distancia_uc_pkg;

    // FSM state codes; the numeric values are visible on db_estado.
    localparam logic [3:0] c_estado_inicial       = 4'b0000;
    localparam logic [3:0] c_estado_preparacao    = 4'b0001;
    localparam logic [3:0] c_estado_envia_trigger = 4'b0010;
    localparam logic [3:0] c_estado_espera_echo   = 4'b0011;
    localparam logic [3:0] c_estado_medida        = 4'b0100;
    localparam logic [3:0] c_estado_armazenamento = 4'b0101;
    localparam logic [3:0] c_estado_final_medida  = 4'b0110;
    localparam logic [3:0] c_estado_erro_timeout  = 4'b0111;

    // Reference clock used to derive the default timing values.
    localparam int c_clock_hz = 50_000_000;

    // 10 us trigger pulse.
    localparam int c_trigger_cycles_default = c_clock_hz / 100_000;

    // 30 ms budget from the end of the trigger until the echo counter is done.
    localparam int c_timeout_cycles_default = (c_clock_hz / 1_000) * 30;

    // Cycle counter width large enough for both defaults above.
    localparam int c_cnt_width_default = 21;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/medidor_distancia_uc_contador_ciclos.sv
`default_nettype none
// ============================================================================
// Module      : contador_ciclos
// Description : Cycle counter used by the measurement control unit to time
//               the trigger pulse and the echo timeout. Synchronous clear has
//               priority over counting; the count saturates at the largest
//               terminal value so it can never wrap around.
// Ports       : clock       - system clock, rising edge
//               reset       - asynchronous active-low reset
//               zera        - synchronous clear
//               conta       - count enable
//               fim_trigger - count equals TRIGGER_CYCLES-1
//               fim_timeout - count equals TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module contador_ciclos
    import medidor_distancia_uc_pkg::*;
#(
    parameter int CNT_WIDTH      = 21,
    parameter int TRIGGER_CYCLES = 500,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim_trigger,
    output logic fim_timeout
);

    localparam logic [CNT_WIDTH-1:0] c_term_trigger = CNT_WIDTH'(TRIGGER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_term_timeout = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_saturacao    =
        CNT_WIDTH'(max_int(TRIGGER_CYCLES, TIMEOUT_CYCLES) - 1);

    logic [CNT_WIDTH-1:0] r_contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_contagem <= '0;
        end else if (zera) begin
            r_contagem <= '0;
        end else if (conta && (r_contagem != c_saturacao)) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign fim_trigger = (r_contagem == c_term_trigger);
    assign fim_timeout = (r_contagem == c_term_timeout);

endmodule
`default_nettype wire

// File: rtl/medidor_distancia_uc.sv
`default_nettype none
// ============================================================================
// Module      : medidor_distancia_uc
// Description : Control unit for one ultrasonic distance measurement. On a
//               request it clears the echo-width datapath, emits the sensor
//               trigger pulse, waits for the echo and for the echo counter's
//               done pulse, then commands the distance register load. Missing
//               or stuck echoes abort the measurement with a timeout pulse.
//               Moore FSM: every output is decoded from the state register.
// Ports       : clock         - system clock, rising edge
//               reset         - asynchronous active-low reset
//               medir         - measurement request (sampled in inicial only)
//               echo          - synchronized sensor echo
//               fim_contagem  - echo-width counter done pulse
//               trigger       - sensor trigger
//               zera_contador - clear for echo counter / distance register
//               registra      - distance register load enable
//               ocupado       - busy (any state except inicial)
//               pronto        - 1-cycle measurement-valid pulse
//               timeout       - 1-cycle measurement-aborted pulse
//               db_estado     - current state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module medidor_distancia_uc
    import medidor_distancia_uc_pkg::*;
#(
    parameter int TRIGGER_CYCLES = c_trigger_cycles_default,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles_default,
    parameter int CNT_WIDTH      = c_cnt_width_default
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       echo,
    input  logic       fim_contagem,
    output logic       trigger,
    output logic       zera_contador,
    output logic       registra,
    output logic       ocupado,
    output logic       pronto,
    output logic       timeout,
    output logic [3:0] db_estado
);

    logic [3:0] r_estado;
    logic [3:0] w_proximo;
    logic       w_zera_ciclos;
    logic       w_conta_ciclos;
    logic       w_fim_trigger;
    logic       w_fim_timeout;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= c_estado_inicial;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            c_estado_inicial: begin
                if (medir) begin
                    w_proximo = c_estado_preparacao;
                end
            end
            c_estado_preparacao: begin
                w_proximo = c_estado_envia_trigger;
            end
            c_estado_envia_trigger: begin
                if (w_fim_trigger) begin
                    w_proximo = c_estado_espera_echo;
                end
            end
            c_estado_espera_echo: begin
                // An echo seen on the terminal cycle still counts as an echo.
                if (echo) begin
                    w_proximo = c_estado_medida;
                end else if (w_fim_timeout) begin
                    w_proximo = c_estado_erro_timeout;
                end
            end
            c_estado_medida: begin
                // Counter completion wins over a simultaneous timeout.
                if (fim_contagem) begin
                    w_proximo = c_estado_armazenamento;
                end else if (w_fim_timeout) begin
                    w_proximo = c_estado_erro_timeout;
                end
            end
            c_estado_armazenamento: begin
                w_proximo = c_estado_final_medida;
            end
            c_estado_final_medida: begin
                w_proximo = c_estado_inicial;
            end
            c_estado_erro_timeout: begin
                w_proximo = c_estado_inicial;
            end
            default: begin
                w_proximo = c_estado_inicial;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cycle counter control
    // ------------------------------------------------------------------
    // The counter restarts on every state change, except espera_echo ->
    // medida: the timeout budget covers the echo wait plus the echo width.
    assign w_zera_ciclos  = (w_proximo != r_estado) &&
                            !((r_estado == c_estado_espera_echo) &&
                              (w_proximo == c_estado_medida));

    assign w_conta_ciclos = (r_estado == c_estado_envia_trigger) ||
                            (r_estado == c_estado_espera_echo)   ||
                            (r_estado == c_estado_medida);

    contador_ciclos #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TRIGGER_CYCLES (TRIGGER_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_contador_ciclos (
        .clock       (clock),
        .reset       (reset),
        .zera        (w_zera_ciclos),
        .conta       (w_conta_ciclos),
        .fim_trigger (w_fim_trigger),
        .fim_timeout (w_fim_timeout)
    );

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign trigger       = (r_estado == c_estado_envia_trigger);
    assign zera_contador = (r_estado == c_estado_preparacao) ||
                           (r_estado == c_estado_erro_timeout);
    assign registra      = (r_estado == c_estado_armazenamento);
    assign ocupado       = (r_estado != c_estado_inicial);
    assign pronto        = (r_estado == c_estado_final_medida);
    assign timeout       = (r_estado == c_estado_erro_timeout);
    assign db_estado     = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_medidor_distancia_uc.sv
`default_nettype none
// ============================================================================
// Module      : tb_medidor_distancia_uc
// Description : Self-checking bench for medidor_distancia_uc. Each scenario
//               fills per-cycle stimulus tables; a timeline model derives the
//               expected state for every cycle from the measurement rules
//               (trigger length, timeout budget, priorities) and the DUT is
//               compared every cycle. A directed mid-trigger reset closes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_medidor_distancia_uc;

    localparam int T    = 5;
    localparam int TO   = 50;
    localparam int NMAX = 512;

    localparam logic [3:0] S_INI = 4'd0;
    localparam logic [3:0] S_PRE = 4'd1;
    localparam logic [3:0] S_TRG = 4'd2;
    localparam logic [3:0] S_ESP = 4'd3;
    localparam logic [3:0] S_MED = 4'd4;
    localparam logic [3:0] S_ARM = 4'd5;
    localparam logic [3:0] S_FIN = 4'd6;
    localparam logic [3:0] S_ERR = 4'd7;

    logic       clock        = 1'b0;
    logic       reset        = 1'b0;
    logic       medir        = 1'b0;
    logic       echo         = 1'b0;
    logic       fim_contagem = 1'b0;
    logic       trigger;
    logic       zera_contador;
    logic       registra;
    logic       ocupado;
    logic       pronto;
    logic       timeout;
    logic [3:0] db_estado;

    medidor_distancia_uc #(
        .TRIGGER_CYCLES (T),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .medir         (medir),
        .echo          (echo),
        .fim_contagem  (fim_contagem),
        .trigger       (trigger),
        .zera_contador (zera_contador),
        .registra      (registra),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .timeout       (timeout),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic       m_a [NMAX];
    logic       e_a [NMAX];
    logic       f_a [NMAX];
    logic [3:0] x_a [NMAX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for a state: {trigger, zera, registra, ocupado, pronto, timeout}
    function automatic logic [5:0] outs_of(input logic [3:0] s);
        return {s == S_TRG, (s == S_PRE) || (s == S_ERR), s == S_ARM,
                s != S_INI, s == S_FIN, s == S_ERR};
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < NMAX; i++) begin
            m_a[i] = 1'b0;
            e_a[i] = 1'b0;
            f_a[i] = 1'b0;
            x_a[i] = S_INI;
        end
    endtask

    task automatic put(input int idx, input logic [3:0] s);
        if (idx < NMAX) x_a[idx] = s;
    endtask

    // Timeline model: a request seen in an idle cycle c yields preparacao at
    // c+1, T trigger cycles, then an echo wait starting at s. The total
    // budget from s is TO cycles (count c-s, capped at TO-1); completion
    // beats timeout; requests during a measurement are dropped.
    task automatic build_expected(input int n);
        int c, s, t, ending;
        logic got_echo;
        c = 0;
        while (c < n) begin
            if (!m_a[c]) begin
                c++;
            end else begin
                put(c + 1, S_PRE);
                for (int k = 0; k < T; k++) put(c + 2 + k, S_TRG);
                s = c + 2 + T;
                t = s;
                ending = -1;
                got_echo = 1'b0;
                while (t < n && ending < 0 && !got_echo) begin
                    put(t, S_ESP);
                    if (e_a[t]) got_echo = 1'b1;
                    else if (t - s == TO - 1) begin
                        put(t + 1, S_ERR);
                        ending = t + 1;
                    end else t++;
                end
                if (got_echo) begin
                    t = t + 1;
                    while (t < n && ending < 0) begin
                        put(t, S_MED);
                        if (f_a[t]) begin
                            put(t + 1, S_ARM);
                            put(t + 2, S_FIN);
                            ending = t + 2;
                        end else if (t - s >= TO - 1) begin
                            put(t + 1, S_ERR);
                            ending = t + 1;
                        end else t++;
                    end
                end
                c = (ending < 0) ? n : ending + 1;
            end
        end
    endtask

    task automatic run_window(input string name, input int n);
        medir = 1'b0; echo = 1'b0; fim_contagem = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        build_expected(n);
        for (int c = 0; c < n; c++) begin
            medir        = m_a[c];
            echo         = e_a[c];
            fim_contagem = f_a[c];
            #4;
            check($sformatf("%s_estado_c%0d", name, c), 32'(db_estado), 32'(x_a[c]));
            check($sformatf("%s_saidas_c%0d", name, c),
                  32'({trigger, zera_contador, registra, ocupado, pronto, timeout}),
                  32'(outs_of(x_a[c])));
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        // Nominal: request at 1, echo wait starts at 8, echo 20 cycles later for 30.
        clear_stim();
        m_a[1] = 1'b1;
        for (int i = 28; i < 58; i++) e_a[i] = 1'b1;
        f_a[60] = 1'b1;
        run_window("nominal", 90);

        // Missing echo.
        clear_stim();
        m_a[0] = 1'b1;
        run_window("sem_echo", 80);

        // Stuck echo: rises 10 cycles after trigger, never falls.
        clear_stim();
        m_a[0] = 1'b1;
        for (int i = 17; i < NMAX; i++) e_a[i] = 1'b1;
        run_window("echo_preso", 80);

        // Counter done on the same cycle as the terminal count (count 49 at 56).
        clear_stim();
        m_a[0] = 1'b1;
        e_a[10] = 1'b1;
        f_a[56] = 1'b1;
        run_window("simultaneo", 80);

        // Echo already high when the wait begins.
        clear_stim();
        m_a[0] = 1'b1;
        for (int i = 3; i < 20; i++) e_a[i] = 1'b1;
        f_a[15] = 1'b1;
        run_window("echo_na_entrada", 40);

        // Request during medida ignored, then held high for back-to-back runs.
        clear_stim();
        m_a[0] = 1'b1;
        for (int i = 12; i < 26; i++) e_a[i] = 1'b1;
        m_a[20] = 1'b1;
        f_a[30] = 1'b1;
        for (int i = 40; i < 400; i++) begin
            m_a[i] = 1'b1;
            e_a[i] = ((i % 37) < 5);
            f_a[i] = ((i % 37) == 10);
        end
        run_window("repete", 400);

        // Randomized traffic.
        for (int w = 0; w < 4; w++) begin
            logic lvl;
            clear_stim();
            lvl = 1'b0;
            for (int i = 0; i < 400; i++) begin
                m_a[i] = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 14) == 0) lvl = ~lvl;
                e_a[i] = lvl;
                f_a[i] = ($urandom_range(0, 19) == 0);
            end
            run_window($sformatf("aleatorio%0d", w), 400);
        end

        // Reset during the third trigger cycle.
        medir = 1'b0; echo = 1'b0; fim_contagem = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        medir = 1'b1;
        @(posedge clock); #1;
        medir = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rst_trigger_antes", 32'(trigger), 32'd1);
        check("rst_estado_antes", 32'(db_estado), 32'(S_TRG));
        #2;
        reset = 1'b0;
        #1;
        check("rst_trigger_async", 32'(trigger), 32'd0);
        check("rst_estado_async", 32'(db_estado), 32'(S_INI));
        check("rst_ocupado_async", 32'(ocupado), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #4;
            check($sformatf("rst_fica_inicial_c%0d", i), 32'(db_estado), 32'(S_INI));
            check($sformatf("rst_saidas_c%0d", i),
                  32'({trigger, zera_contador, registra, ocupado, pronto, timeout}), 32'd0);
            @(posedge clock); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/medidor_distancia_uc.md
Name: medidor_distancia_uc

Overview:
Control unit that runs one complete ultrasonic distance measurement.
- On a request, it clears the cm-counting datapath and emits the sensor trigger pulse.
- It then waits for the echo pulse and for the counter's done indication, and commands the distance register load.
- It times out when echo is missing or stuck high.
- It sits between the top-level sequencer (issues medir, consumes pronto/timeout) and the echo-width counter plus distance register.

Parameters:
TRIGGER_CYCLES, 500, trigger high width in clocks (10 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, maximum clocks allowed from trigger end to counter done (30 ms at 50 MHz)
CNT_WIDTH, 21, width of internal cycle counter; must satisfy 2^CNT_WIDTH > max(TRIGGER_CYCLES, TIMEOUT_CYCLES)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
medir  input  1  measurement request, level; sampled only in state inicial
echo  input  1  sensor echo, already synchronized to clock
fim_contagem  input  1  counter done pulse (echo-width counter finished, 1 cycle)
trigger  output  1  sensor trigger
zera_contador  output  1  synchronous clear for echo counter and distance register
registra  output  1  load enable for distance register
ocupado  output  1  high in every state except inicial
pronto  output  1  1-cycle pulse, measurement valid
timeout  output  1  1-cycle pulse, measurement aborted
db_estado  output  4  current state code, debug

Behaviour:
- Reset value: all outputs 0 and db_estado=0000.
- Reset asserted mid-operation: state inicial immediately; trigger drops asynchronously; cycle counter cleared.
- Moore FSM; all outputs decode from the registered state only.
- Internal cycle counter: cleared on every state change; increments each cycle while in envia_trigger, espera_echo or medida.
- States, codes and transitions:
  - inicial (0000): if medir=1, go to preparacao; else stay.
  - preparacao (0001): zera_contador=1; always go to envia_trigger after 1 cycle.
  - envia_trigger (0010): trigger=1; when count = TRIGGER_CYCLES-1, go to espera_echo. Trigger is high for exactly TRIGGER_CYCLES cycles.
  - espera_echo (0011): if echo=1, go to medida. If echo=0 and count = TIMEOUT_CYCLES-1, go to erro_timeout.
  - medida (0100): do not clear the counter on entry; it continues from espera_echo so the timeout budget is total. If fim_contagem=1, go to armazenamento. Otherwise, if count = TIMEOUT_CYCLES-1, go to erro_timeout.
  - armazenamento (0101): registra=1; go to final_medida.
  - final_medida (0110): pronto=1; go to inicial.
  - erro_timeout (0111): timeout=1 and zera_contador=1; go to inicial.
  - Unused codes go to inicial.
- ocupado=1 in all states except inicial.
- Latency: medir seen at edge k gives preparacao at k+1. trigger is high from k+2 through k+1+TRIGGER_CYCLES. pronto is high exactly 2 cycles after the edge that samples fim_contagem=1.
- medir during ocupado: ignored, no queueing.
- medir held high continuously: back-to-back measurements, with one inicial cycle between them.
- fim_contagem and the timeout terminal count in the same cycle: fim_contagem wins.
- fim_contagem outside medida: ignored.
- echo already high on entry to espera_echo: go to medida next cycle.
- Counter saturates at the terminal count; it never wraps.

Decomposition:
- Shared package: 4-bit state codes above, plus default TRIGGER_CYCLES and TIMEOUT_CYCLES constants derived from a 50 MHz clock.
- One sub-module: contador_ciclos.
  - Parameterized CNT_WIDTH up-counter with synchronous zera, conta enable, and active-low async reset.
  - Provides the comparisons against TRIGGER_CYCLES-1 and TIMEOUT_CYCLES-1.
- FSM register, next-state logic and output decode stay in medidor_distancia_uc.

Test Plan (bench uses TRIGGER_CYCLES=5, TIMEOUT_CYCLES=50):
- Nominal measurement. Stimulus: medir 1 cycle; echo high 20 cycles after trigger falls, for 30 cycles; fim_contagem 2 cycles after echo falls. Response: zera_contador 1 cycle, then trigger high exactly 5 cycles, registra 1 cycle, then pronto 1 cycle; ocupado low afterwards.
- Missing echo. Stimulus: medir, echo never rises. Response: timeout pulses 50 cycles after trigger falls, zera_contador=1 in the same cycle, pronto never asserts, FSM returns to 0000.
- Stuck echo. Stimulus: echo rises 10 cycles after trigger and never falls, no fim_contagem. Response: timeout at total count 49 from espera_echo entry.
- Simultaneous events. Stimulus: fim_contagem arrives in the same cycle as the terminal count. Response: registra then pronto; no timeout.
- Ignore and repeat. Stimulus: medir pulsed during medida, then held high. Response: first measurement unaffected; afterwards back-to-back measurements with 1 inicial cycle between pronto and the next preparacao.
- Reset mid-trigger. Stimulus: reset=0 during cycle 3 of trigger. Response: trigger=0 asynchronously, db_estado=0000; after reset=1 with medir=0, the FSM stays in inicial.
